// File: rtl/ex_div_if.sv
// ex_div_if: divider request/result bundle; master = execute stage, slave = divider
interface ex_div_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
  modport slave (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider (DIV/DIVU); ports clk, rst (async high), bus = ex_div_if slave, result {rem, quot}
module ex_div #(
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  ex_div_if.slave   bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} state_t;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dend_q, dend_d;
  logic [DATA_W-1:0]   dsor_q, dsor_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W:0]     shifted, trial;
  logic                op1_neg, op2_neg;
  // dend_q shifts dividend bits out of its MSB while quotient bits enter at its LSB
  assign shifted = {rem_q, dend_q[DATA_W-1]};
  assign trial   = shifted - {1'b0, dsor_q};
  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dend_q     <= '0;
      dsor_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dend_q     <= dend_d;
      dsor_q     <= dsor_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dend_d     = dend_q;
    dsor_d     = dsor_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DIV_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            dend_d     = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
            dsor_d     = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          rem_d  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
          dend_d = {dend_q[DATA_W-2:0], ~trial[DATA_W]};
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          result_d = {neg_rem_q ? -rem_q : rem_q, neg_quot_q ? -dend_q : dend_q};
          ready_d  = 1'b1;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end
  always_comb begin
    bus.result_o = result_q;
    bus.ready_o  = ready_q;
  end
endmodule
